eth_rst_seq: RTL and testbench
==============================

Name: eth_rst_seq

Overview:
- Consumes the asynchronous MMCM lock indication produced by the Ethernet clock manager, in the 125 MHz Ethernet clock domain.
- Generates an ordered reset release for the Ethernet subsystem: external PHY reset pulse, PHY settle wait, MAC reset release, then core/AXI reset release.
- Any loss of lock, or a software reset request, re-runs the sequence so downstream logic never runs on an unlocked clock.

Parameters:
- SYNC_STAGES, 2: flops in the clk_locked_in synchronizer; minimum 2.
- LOCK_STABLE_CYC, 1024: consecutive cycles synchronized lock must stay high before sequencing starts; minimum 1.
- PHY_RST_CYC, 1250000: cycles phy_rst_n is held low (10 ms at 125 MHz); minimum 1.
- PHY_SETTLE_CYC, 125000: cycles after PHY reset release before the MAC is released; minimum 1.
- MAC_RST_CYC, 16: cycles between mac_rst release and core_rst release; minimum 1.

Ports:
- clk_in, input, 1: Ethernet clock (125 MHz).
- rst_in, input, 1: reset, synchronous, active-high.
- clk_locked_in, input, 1: MMCM lock; asynchronous to clk_in.
- sw_rst_req, input, 1: single-cycle software request to re-run the PHY/MAC sequence.
- phy_rst_n, output, 1: external PHY reset, active-low.
- mac_rst, output, 1: MAC reset, active-high.
- core_rst, output, 1: AXI/core reset, active-high.
- seq_done, output, 1: high while in RUN.
- seq_state, output, 3: current state encoding, for debug/CSR.

Behaviour:
- Reset (rst_in=1 at a rising edge):
  - State becomes WAIT_LOCK; counter and synchronizer flops clear.
  - Outputs: phy_rst_n=0, mac_rst=1, core_rst=1, seq_done=0, seq_state=1.
- Synchronizer: lock_s is clk_locked_in delayed through SYNC_STAGES flops. Only lock_s is used internally.
- State encoding: WAIT_LOCK=1, PHY_RST=2, PHY_SETTLE=3, MAC_REL=4, RUN=5. Codes 0, 6 and 7 are illegal and go to WAIT_LOCK.
- Single counter, width clog2 of the largest *_CYC parameter. Cleared on every state transition.
- Outputs are registered and updated on the same edge as the state register, so they always reflect the current state:
  - WAIT_LOCK: phy_rst_n=0, mac_rst=1, core_rst=1.
  - PHY_RST: phy_rst_n=0, mac_rst=1, core_rst=1.
  - PHY_SETTLE: phy_rst_n=1, mac_rst=1, core_rst=1.
  - MAC_REL: phy_rst_n=1, mac_rst=0, core_rst=1.
  - RUN: phy_rst_n=1, mac_rst=0, core_rst=0, seq_done=1.
- Transitions:
  - WAIT_LOCK: counter increments while lock_s=1 and clears while lock_s=0. When lock_s=1 and count==LOCK_STABLE_CYC-1, go to PHY_RST.
  - PHY_RST: go to PHY_SETTLE when count==PHY_RST_CYC-1. The state therefore lasts exactly PHY_RST_CYC cycles.
  - PHY_SETTLE: go to MAC_REL after exactly PHY_SETTLE_CYC cycles.
  - MAC_REL: go to RUN after exactly MAC_RST_CYC cycles.
  - RUN: held indefinitely.
- Lock loss: lock_s=0 in PHY_RST, PHY_SETTLE, MAC_REL or RUN goes to WAIT_LOCK at the next edge. All resets assert together at that edge; there is no ordered assertion.
- sw_rst_req=1 in RUN goes to PHY_RST, asserting all resets together and skipping the lock-stable wait. sw_rst_req is ignored in every other state.
- Priority: rst_in > lock loss > sw_rst_req > counter expiry.
- Latency: with clk_locked_in first sampled high at edge E0 and held high, PHY_RST is entered at edge E0+SYNC_STAGES+LOCK_STABLE_CYC-1. Each later state lasts exactly its parameter count.
- Glitch rule: clk_locked_in pulses shorter than LOCK_STABLE_CYC never leave WAIT_LOCK.

Test Plan:
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYC=8, PHY_RST_CYC=20, PHY_SETTLE_CYC=10, MAC_RST_CYC=4.
1. Reset and power-up, clk_locked_in held low: rst_in for 3 cycles then low for 100 cycles -> phy_rst_n=0, mac_rst=1, core_rst=1, seq_done=0, seq_state=1 throughout.
2. Nominal sequence, clk_locked_in rises before edge E0 -> seq_state=2 after E0+9; phy_rst_n rises after E0+29; mac_rst falls after E0+39; core_rst falls and seq_done rises after E0+43.
3. Lock glitch: clk_locked_in high for 5 cycles, low for 3, then high -> stays in WAIT_LOCK; PHY_RST entered 8 lock_s-high cycles after the final rise.
4. Lock loss in RUN: drop clk_locked_in -> two edges later all resets assert and seq_state=1 in the same cycle; restoring lock replays scenario 2 timing.
5. Software request: sw_rst_req pulse in RUN -> next edge seq_state=2 and phy_rst_n=0; seq_done returns 34 cycles later. A pulse during PHY_SETTLE changes nothing.
6. Simultaneous events: lock loss and sw_rst_req in the same RUN cycle -> WAIT_LOCK wins. rst_in asserted in MAC_REL -> WAIT_LOCK with reset values next edge.

Source files
------------

// File: rtl/eth_rst_seq.sv
// Ethernet reset sequencer, clk_in (125 MHz) domain.
// Waits for a stable MMCM lock, then releases resets in order: PHY reset
// pulse, PHY settle wait, MAC release, and finally core/AXI release.
// A loss of lock or a software request re-runs the sequence.
module eth_rst_seq #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned PHY_RST_CYC     = 1250000,
  parameter int unsigned PHY_SETTLE_CYC  = 125000,
  parameter int unsigned MAC_RST_CYC     = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clk_locked_in,
  input  logic       sw_rst_req,
  output logic       phy_rst_n,
  output logic       mac_rst,
  output logic       core_rst,
  output logic       seq_done,
  output logic [2:0] seq_state
);

  // One counter serves every state, so size it for the longest interval.
  localparam int unsigned MAX_AB  = (LOCK_STABLE_CYC > PHY_RST_CYC) ? LOCK_STABLE_CYC : PHY_RST_CYC;
  localparam int unsigned MAX_CD  = (PHY_SETTLE_CYC > MAC_RST_CYC) ? PHY_SETTLE_CYC : MAC_RST_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MAC_LAST    = CNT_W'(MAC_RST_CYC - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK  = 3'd1,
    S_PHY_RST    = 3'd2,
    S_PHY_SETTLE = 3'd3,
    S_MAC_REL    = 3'd4,
    S_RUN        = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_phy_rst_n;
  logic                   w_mac_rst;
  logic                   w_core_rst;
  logic                   w_seq_done;

  // Lock synchronizer: only the last stage is used anywhere else.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_locked_in};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Next state and counter; lock loss outranks the software request,
  // which outranks counter expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    case (r_state)
      S_WAIT_LOCK: begin
        if (!w_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = S_PHY_RST;
          w_cnt_nxt   = '0;
        end
      end
      S_PHY_RST: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PHY_LAST) begin
          w_state_nxt = S_PHY_SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      S_PHY_SETTLE: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_MAC_REL;
          w_cnt_nxt   = '0;
        end
      end
      S_MAC_REL: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == MAC_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        // Counter is idle in RUN; holding it at zero avoids a free-running wrap.
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (sw_rst_req) begin
          w_state_nxt = S_PHY_RST;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs change on
  // the same edge as the state register.
  always_comb begin
    w_phy_rst_n = 1'b0;
    w_mac_rst   = 1'b1;
    w_core_rst  = 1'b1;
    w_seq_done  = 1'b0;
    case (w_state_nxt)
      S_PHY_SETTLE: begin
        w_phy_rst_n = 1'b1;
      end
      S_MAC_REL: begin
        w_phy_rst_n = 1'b1;
        w_mac_rst   = 1'b0;
      end
      S_RUN: begin
        w_phy_rst_n = 1'b1;
        w_mac_rst   = 1'b0;
        w_core_rst  = 1'b0;
        w_seq_done  = 1'b1;
      end
      default: begin
        w_phy_rst_n = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_WAIT_LOCK;
      r_cnt     <= '0;
      phy_rst_n <= 1'b0;
      mac_rst   <= 1'b1;
      core_rst  <= 1'b1;
      seq_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      phy_rst_n <= w_phy_rst_n;
      mac_rst   <= w_mac_rst;
      core_rst  <= w_core_rst;
      seq_done  <= w_seq_done;
    end
  end

  assign seq_state = r_state;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Bench for eth_rst_seq: directed scenarios followed by random lock,
// software-request and reset activity, checked against a timeline model.
module tb_eth_rst_seq;

  localparam int unsigned T_PHY    = 20;
  localparam int unsigned T_SETTLE = 10;
  localparam int unsigned T_MAC    = 4;
  localparam int unsigned T_LOCK   = 8;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       clk_locked_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       phy_rst_n;
  logic       mac_rst;
  logic       core_rst;
  logic       seq_done;
  logic [2:0] seq_state;

  always #4 clk_in = ~clk_in;

  eth_rst_seq #(
    .SYNC_STAGES    (2),
    .LOCK_STABLE_CYC(T_LOCK),
    .PHY_RST_CYC    (T_PHY),
    .PHY_SETTLE_CYC (T_SETTLE),
    .MAC_RST_CYC    (T_MAC)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clk_locked_in(clk_locked_in),
    .sw_rst_req   (sw_rst_req),
    .phy_rst_n    (phy_rst_n),
    .mac_rst      (mac_rst),
    .core_rst     (core_rst),
    .seq_done     (seq_done),
    .seq_state    (seq_state)
  );

  int total = 0;
  int bad   = 0;

  // Expected {phy_rst_n, mac_rst, core_rst, seq_done, seq_state} per edge.
  logic [6:0] exp_q[$];

  // Model: lock history, a run of consecutive stable-lock cycles, and the
  // time elapsed since the sequence last (re)started at PHY reset.
  bit [1:0] m_pipe    = '0;
  bit       m_started = 1'b0;
  int       m_stable  = 0;
  int       m_elapsed = 0;

  function automatic logic [6:0] expect_of(input bit started, input int el);
    if (!started)                        return {1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    if (el < T_PHY)                      return {1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    if (el < T_PHY + T_SETTLE)           return {1'b1, 1'b1, 1'b1, 1'b0, 3'd3};
    if (el < T_PHY + T_SETTLE + T_MAC)   return {1'b1, 1'b0, 1'b1, 1'b0, 3'd4};
    return {1'b1, 1'b0, 1'b0, 1'b1, 3'd5};
  endfunction

  // Drive one cycle of inputs and advance the model across the next edge.
  task automatic step(input logic r, input logic l, input logic s);
    bit lock_s;
    bit in_run;
    @(negedge clk_in);
    rst_in        = r;
    clk_locked_in = l;
    sw_rst_req    = s;
    lock_s = m_pipe[1];
    in_run = m_started && (m_elapsed >= int'(T_PHY + T_SETTLE + T_MAC));
    if (r) begin
      m_pipe    = '0;
      m_started = 1'b0;
      m_stable  = 0;
      m_elapsed = 0;
    end else begin
      if (m_started) begin
        if (!lock_s) begin
          m_started = 1'b0;
          m_stable  = 0;
        end else if (in_run && s) begin
          m_elapsed = 0;
        end else if (m_elapsed < int'(T_PHY + T_SETTLE + T_MAC)) begin
          m_elapsed++;
        end
      end else if (lock_s) begin
        m_stable++;
        if (m_stable == int'(T_LOCK)) begin
          m_started = 1'b1;
          m_elapsed = 0;
          m_stable  = 0;
        end
      end else begin
        m_stable = 0;
      end
      m_pipe = {m_pipe[0], l};
    end
    exp_q.push_back(expect_of(m_started, m_elapsed));
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    logic [6:0] e;
    logic [6:0] a;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {phy_rst_n, mac_rst, core_rst, seq_done, seq_state};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t {phy_n,mac,core,done,state} got=%b_%b_%b_%b_%0d want=%b_%b_%b_%b_%0d",
                   $time, a[6], a[5], a[4], a[3], a[2:0], e[6], e[5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  initial begin
    int unsigned lock_low_left;
    // Reset, then power-up with lock low.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (100) step(1'b0, 1'b0, 1'b0);
    // Nominal sequence through to RUN.
    repeat (60) step(1'b0, 1'b1, 1'b0);
    // Software request in RUN, then a second request during PHY_SETTLE.
    step(1'b0, 1'b1, 1'b1);
    repeat (24) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b1, 1'b0);
    // Lock loss in RUN, then recovery.
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (60) step(1'b0, 1'b1, 1'b0);
    // Lock glitch: 5 high, 3 low, then high.
    repeat (10) step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (60) step(1'b0, 1'b1, 1'b0);
    // Lock loss coinciding with sw_rst_req at the synchronized edge.
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1, 1'b0);
    // rst_in while in MAC_REL.
    step(1'b0, 1'b1, 1'b1);
    repeat (31) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b1, 1'b0);
    // Random traffic: mostly locked, with short and long dropouts.
    lock_low_left = 0;
    for (int i = 0; i < 4000; i++) begin
      logic l;
      logic s;
      logic r;
      if (lock_low_left == 0 && $urandom_range(0, 99) < 2)
        lock_low_left = $urandom_range(1, 12);
      l = (lock_low_left == 0);
      if (lock_low_left > 0) lock_low_left--;
      s = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 999) < 3);
      step(r, l, s);
    end
    repeat (3) @(posedge clk_in);
    #2;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
